// File: rtl/cpu_fetch_pkg.sv
// +------------------------------------------------------------------+
// | cpu_fetch_pkg: shared types and opcode-length decode for fetch    |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

package cpu_fetch_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH_OP = 3'd1,
    FETCH_LO = 3'd2,
    FETCH_HI = 3'd3,
    HOLD     = 3'd4
  } fetch_state_t;

  localparam logic [1:0] OPC_LEN_1A = 2'b00;
  localparam logic [1:0] OPC_LEN_2  = 2'b01;
  localparam logic [1:0] OPC_LEN_3  = 2'b10;
  localparam logic [1:0] OPC_LEN_1B = 2'b11;

  // Instruction length in bytes is encoded in the two opcode MSBs.
  function automatic logic [1:0] instr_len_f(input logic [7:0] opcode);
    logic [1:0] len;
    len = 2'd1;
    case (opcode[7:6])
      OPC_LEN_1A: len = 2'd1;
      OPC_LEN_2:  len = 2'd2;
      OPC_LEN_3:  len = 2'd3;
      OPC_LEN_1B: len = 2'd1;
    endcase
    return len;
  endfunction

endpackage

`default_nettype wire

// File: rtl/register_8bit.sv
// +------------------------------------------------------------------+
// | register_8bit: byte register with load enable, async reset to 0   |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module register_8bit (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_en,
  input  logic [7:0] d,
  output logic [7:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= 8'h00;
    end else if (load_en) begin
      q <= d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// +------------------------------------------------------------------+
// | instr_fetch_unit: PC owner, byte fetcher and instruction assembler|
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module instr_fetch_unit
  import cpu_fetch_pkg::*;
#(
  parameter logic [15:0] RESET_VECTOR = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  input  logic        jump_en,
  input  logic [15:0] jump_addr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [7:0]  instr_opcode,
  output logic [15:0] instr_operand,
  output logic [1:0]  instr_len,
  output logic [15:0] instr_pc,
  output logic [15:0] pc
);

  fetch_state_t state;
  logic         xfer;
  logic         op_load;
  logic         lo_load;
  logic         hi_load;
  logic [7:0]   byte1;
  logic [7:0]   byte2;
  logic [1:0]   len_new;

  assign mem_req     = (state == FETCH_OP) || (state == FETCH_LO) || (state == FETCH_HI);
  assign mem_addr    = pc;
  assign instr_valid = (state == HOLD);

  // A byte accepted in the same cycle as a redirect is thrown away.
  assign xfer    = mem_req && mem_ack && !jump_en;
  assign op_load = xfer && (state == FETCH_OP);
  assign lo_load = xfer && (state == FETCH_LO);
  assign hi_load = xfer && (state == FETCH_HI);
  assign len_new = instr_len_f(mem_rdata);

  register_8bit u_opcode (
    .clk     (clk),
    .reset   (reset),
    .load_en (op_load),
    .d       (mem_rdata),
    .q       (instr_opcode)
  );

  // Operand bytes are cleared on each opcode so shorter instructions read zero.
  register_8bit u_byte1 (
    .clk     (clk),
    .reset   (reset),
    .load_en (op_load || lo_load),
    .d       (lo_load ? mem_rdata : 8'h00),
    .q       (byte1)
  );

  register_8bit u_byte2 (
    .clk     (clk),
    .reset   (reset),
    .load_en (op_load || hi_load),
    .d       (hi_load ? mem_rdata : 8'h00),
    .q       (byte2)
  );

  assign instr_operand = {byte2, byte1};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pc        <= RESET_VECTOR;
      instr_len <= 2'd0;
      instr_pc  <= 16'h0000;
    end else if (jump_en) begin
      state <= FETCH_OP;
      pc    <= jump_addr;
    end else begin
      case (state)
        IDLE: state <= FETCH_OP;
        FETCH_OP: begin
          if (xfer) begin
            instr_len <= len_new;
            instr_pc  <= pc;
            pc        <= pc + 16'd1;
            state     <= (len_new == 2'd1) ? HOLD : FETCH_LO;
          end
        end
        FETCH_LO: begin
          if (xfer) begin
            pc    <= pc + 16'd1;
            state <= (instr_len == 2'd2) ? HOLD : FETCH_HI;
          end
        end
        FETCH_HI: begin
          if (xfer) begin
            pc    <= pc + 16'd1;
            state <= HOLD;
          end
        end
        HOLD: begin
          if (instr_ready) state <= FETCH_OP;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// +------------------------------------------------------------------+
// | tb_instr_fetch_unit: directed self-checking bench for fetch unit  |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module tb_instr_fetch_unit;

  logic        clk;
  logic        reset;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        jump_en;
  logic [15:0] jump_addr;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  instr_opcode;
  logic [15:0] instr_operand;
  logic [1:0]  instr_len;
  logic [15:0] instr_pc;
  logic [15:0] pc;

  logic [7:0]  mem [0:65535];
  int          n_cmp;
  int          n_bad;

  instr_fetch_unit #(.RESET_VECTOR(16'h0000)) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .jump_en       (jump_en),
    .jump_addr     (jump_addr),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr_opcode  (instr_opcode),
    .instr_operand (instr_operand),
    .instr_len     (instr_len),
    .instr_pc      (instr_pc),
    .pc            (pc)
  );

  assign mem_rdata = mem[mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int cycles);
    cycles = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      cycles++;
      if (instr_valid) return;
    end
    check("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic redirect(input logic [15:0] addr);
    jump_en   = 1'b1;
    jump_addr = addr;
    tick();
    jump_en   = 1'b0;
  endtask

  task automatic check_instr(input string tag, input logic [7:0] op, input logic [15:0] opnd,
                             input logic [1:0] len, input logic [15:0] ipc, input logic [15:0] npc);
    check({tag, "_opcode"}, {24'd0, instr_opcode}, {24'd0, op});
    check({tag, "_operand"}, {16'd0, instr_operand}, {16'd0, opnd});
    check({tag, "_len"}, {30'd0, instr_len}, {30'd0, len});
    check({tag, "_ipc"}, {16'd0, instr_pc}, {16'd0, ipc});
    check({tag, "_pc"}, {16'd0, pc}, {16'd0, npc});
  endtask

  initial begin
    int cyc;
    n_cmp = 0;
    n_bad = 0;
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    mem[16'h0000] = 8'h05;
    mem[16'h0010] = 8'h80; mem[16'h0011] = 8'h34; mem[16'h0012] = 8'h12;
    mem[16'h0020] = 8'h40; mem[16'h0021] = 8'hAB;
    mem[16'h0030] = 8'hC7;
    mem[16'h0040] = 8'h00; mem[16'h0041] = 8'h01;
    mem[16'h0050] = 8'h80; mem[16'h0051] = 8'h11; mem[16'h0052] = 8'h22;
    mem[16'h0060] = 8'h80; mem[16'h0061] = 8'h55; mem[16'h0062] = 8'h66;
    mem[16'h2000] = 8'h01;
    mem[16'hFFFE] = 8'h81; mem[16'hFFFF] = 8'hCD;

    reset = 1'b1; mem_ack = 1'b1; instr_ready = 1'b1; jump_en = 1'b0; jump_addr = 16'h0000;
    tick(); tick();
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_pc", {16'd0, pc}, 32'h0000);
    check("rst_opcode", {24'd0, instr_opcode}, 32'd0);

    // Release and first fetch of a 1-byte opcode
    reset = 1'b0;
    check("idle_req", {31'd0, mem_req}, 32'd0);
    tick();
    check("first_req", {31'd0, mem_req}, 32'd1);
    check("first_addr", {16'd0, mem_addr}, 32'h0000);
    wait_valid(cyc);
    check("lat1", cyc, 32'd1);
    check_instr("t1", 8'h05, 16'h0000, 2'd1, 16'h0000, 16'h0001);
    mem[16'h0000] = 8'hEF;

    // 3-byte, then 2-byte and 1-byte following it
    redirect(16'h0010);
    wait_valid(cyc);
    check("lat3", cyc, 32'd3);
    check_instr("t3b", 8'h80, 16'h1234, 2'd3, 16'h0010, 16'h0013);
    redirect(16'h0020);
    wait_valid(cyc);
    check_instr("t2b", 8'h40, 16'h00AB, 2'd2, 16'h0020, 16'h0022);
    redirect(16'h0030);
    wait_valid(cyc);
    check_instr("t1b", 8'hC7, 16'h0000, 2'd1, 16'h0030, 16'h0031);

    // Back-to-back 1-byte instructions
    redirect(16'h0040);
    wait_valid(cyc);
    check("b2b_op0", {24'd0, instr_opcode}, 32'h00);
    wait_valid(cyc);
    check("b2b_gap", cyc, 32'd2);
    check("b2b_op1", {24'd0, instr_opcode}, 32'h01);

    // Memory stall mid-instruction
    mem_ack = 1'b0;
    redirect(16'h0050);
    tick();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("stall_req", {31'd0, mem_req}, 32'd1);
      check("stall_addr", {16'd0, mem_addr}, 32'h0051);
      tick();
    end
    check("stall_pc", {16'd0, pc}, 32'h0051);
    mem_ack = 1'b1;
    instr_ready = 1'b0;
    wait_valid(cyc);
    check_instr("stall", 8'h80, 16'h2211, 2'd3, 16'h0050, 16'h0053);

    // Decode backpressure holds the instruction
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", {31'd0, instr_valid}, 32'd1);
      check("bp_req", {31'd0, mem_req}, 32'd0);
      check("bp_operand", {16'd0, instr_operand}, 32'h2211);
    end
    instr_ready = 1'b1;
    tick();
    check("bp_release_valid", {31'd0, instr_valid}, 32'd0);
    check("bp_release_addr", {16'd0, mem_addr}, 32'h0053);

    // Instruction straddling the PC wrap
    redirect(16'hFFFE);
    wait_valid(cyc);
    check_instr("wrap", 8'h81, 16'hEFCD, 2'd3, 16'hFFFE, 16'h0001);

    // Redirect during FETCH_LO with a concurrent ack
    redirect(16'h0060);
    tick();
    redirect(16'h2000);
    check("jlo_valid", {31'd0, instr_valid}, 32'd0);
    check("jlo_req", {31'd0, mem_req}, 32'd1);
    check("jlo_addr", {16'd0, mem_addr}, 32'h2000);
    wait_valid(cyc);
    check_instr("jlo", 8'h01, 16'h0000, 2'd1, 16'h2000, 16'h2001);

    // Redirect while holding an instruction
    instr_ready = 1'b0;
    redirect(16'h0030);
    wait_valid(cyc);
    redirect(16'h0040);
    check("jhold_valid", {31'd0, instr_valid}, 32'd0);
    check("jhold_addr", {16'd0, mem_addr}, 32'h0040);
    instr_ready = 1'b1;

    // Asynchronous reset in FETCH_HI
    redirect(16'h0010);
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    check("arst_req", {31'd0, mem_req}, 32'd0);
    check("arst_valid", {31'd0, instr_valid}, 32'd0);
    check_instr("arst", 8'h00, 16'h0000, 2'd0, 16'h0000, 16'h0000);
    tick();
    reset = 1'b0;
    check("arst_idle_req", {31'd0, mem_req}, 32'd0);
    tick();
    check("arst_first_addr", {16'd0, mem_addr}, 32'h0000);
    wait_valid(cyc);
    check_instr("arst_re", 8'hEF, 16'h0000, 2'd1, 16'h0000, 16'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
